// File: rtl/ps2_mac_kbd_fifo.sv
// PS/2 set-2 byte decoder feeding a key-event FIFO, drained by the Mac Plus
// keyboard command/reply engine (test, model, instant, inquiry).
module ps2_mac_kbd_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PACE_W     = 22,
  parameter int unsigned TICK_SHORT = 'h000fff,
  parameter int unsigned TICK_LONG  = 'h3fffff,
  parameter logic [7:0]  MODEL_ID   = 8'h03,
  parameter logic [7:0]  TEST_ACK   = 8'h7d
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce,
  input  logic [7:0]                    ibyte,
  input  logic                          istrobe,
  output logic [8:0]                    key_addr,
  input  logic [8:0]                    key_code,
  input  logic [7:0]                    data_out,
  input  logic                          strobe_out,
  output logic [7:0]                    data_in,
  output logic                          strobe_in,
  output logic                          capslock,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned       AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [PACE_W-1:0] T_SHORT   = PACE_W'(TICK_SHORT);
  localparam logic [PACE_W-1:0] T_LONG    = PACE_W'(TICK_LONG);
  localparam logic [7:0]        NULL_BYTE = 8'h7b;
  localparam logic [7:0]        KP_PREFIX = 8'h79;
  localparam logic [8:0]        CAPS_ADDR = 9'h058;

  // ---------------- PS/2 prefix decoder ----------------
  logic       brk_reg, ext_reg;
  logic [2:0] skip_reg;
  logic [8:0] key_addr_reg;
  logic       look_reg, look_brk_reg;
  logic       ev_reg, ev_brk_reg;
  logic [8:0] ev_addr_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      brk_reg      <= 1'b0;
      ext_reg      <= 1'b0;
      skip_reg     <= 3'd0;
      key_addr_reg <= 9'h000;
      look_reg     <= 1'b0;
      look_brk_reg <= 1'b0;
      ev_reg       <= 1'b0;
      ev_brk_reg   <= 1'b0;
      ev_addr_reg  <= 9'h000;
    end else begin
      // ROM data lags key_addr by one clk, so the event is resolved one stage later
      look_reg    <= 1'b0;
      ev_reg      <= look_reg;
      ev_brk_reg  <= look_brk_reg;
      ev_addr_reg <= key_addr_reg;
      if (istrobe) begin
        if (skip_reg != 3'd0) begin
          skip_reg <= skip_reg - 3'd1;
        end else begin
          case (ibyte)
            8'hE1: skip_reg <= 3'd7;
            8'hF0: brk_reg  <= 1'b1;
            8'hE0: ext_reg  <= 1'b1;
            8'hFA, 8'hAA, 8'hEE, 8'hFE: begin end
            default: begin
              key_addr_reg <= {ext_reg, ibyte};
              look_brk_reg <= brk_reg;
              look_reg     <= 1'b1;
              ext_reg      <= 1'b0;
              brk_reg      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // ---------------- event rules ----------------
  logic       capslock_reg, caps_held_reg;
  logic       ev_mapped, ev_caps;
  logic       push_req;
  logic [8:0] push_data;
  logic       key_code_unused;

  assign key_code_unused = key_code[7];
  assign ev_mapped = key_code[6:0] != 7'h7b;
  assign ev_caps   = ev_addr_reg == CAPS_ADDR;

  always_comb begin
    push_req  = 1'b0;
    push_data = {key_code[8], ev_brk_reg, key_code[6:0]};
    if (ev_reg && ev_mapped) begin
      if (ev_caps) begin
        // locking key: up bit reflects the new lock state, not the physical key
        push_req  = !ev_brk_reg && !caps_held_reg;
        push_data = {key_code[8], capslock_reg, key_code[6:0]};
      end else begin
        push_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      capslock_reg  <= 1'b0;
      caps_held_reg <= 1'b0;
    end else if (ev_reg && ev_mapped && ev_caps) begin
      if (ev_brk_reg) begin
        caps_held_reg <= 1'b0;
      end else if (!caps_held_reg) begin
        caps_held_reg <= 1'b1;
        capslock_reg  <= ~capslock_reg;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          fifo_empty, fifo_full, push_ok, pop, flush;
  logic [8:0]    head;

  assign fifo_empty = count_reg == '0;
  assign fifo_full  = count_reg == DEPTH_L;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) overflow_reg <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // ---------------- Mac command engine ----------------
  logic [PACE_W-1:0] pace_reg;
  logic cmd_test_reg, cmd_model_reg, cmd_instant_reg, cmd_inq_reg, kp_phase_reg;
  logic at_short, past_short, at_long;
  logic fire_test, fire_model, fire_instant, fire_inq, fire;
  logic kp_set, kp_clr;
  logic [7:0] reply_byte;

  assign at_short     = pace_reg == T_SHORT;
  assign past_short   = pace_reg >= T_SHORT;
  assign at_long      = pace_reg == T_LONG;
  assign fire_test    = cmd_test_reg && at_short;
  assign fire_model   = cmd_model_reg && at_short;
  assign fire_instant = cmd_instant_reg && at_short;
  assign fire_inq     = cmd_inq_reg && past_short && (!fifo_empty || at_long);
  // a fresh command in the same ce cycle supersedes any pending reply
  assign fire = ce && !strobe_out && (fire_test || fire_model || fire_instant || fire_inq);

  always_comb begin
    reply_byte = NULL_BYTE;
    pop        = 1'b0;
    kp_set     = 1'b0;
    kp_clr     = 1'b0;
    flush      = 1'b0;
    if (fire) begin
      if (fire_test) begin
        reply_byte = TEST_ACK;
      end else if (fire_model) begin
        reply_byte = MODEL_ID;
        flush      = 1'b1;
      end else if (!fifo_empty) begin
        if (head[8] && !kp_phase_reg) begin
          reply_byte = KP_PREFIX;
          kp_set     = 1'b1;
        end else begin
          reply_byte = head[7:0];
          pop        = 1'b1;
          kp_clr     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pace_reg        <= '0;
      cmd_test_reg    <= 1'b0;
      cmd_model_reg   <= 1'b0;
      cmd_instant_reg <= 1'b0;
      cmd_inq_reg     <= 1'b0;
      kp_phase_reg    <= 1'b0;
    end else if (ce) begin
      if (strobe_out) begin
        pace_reg        <= '0;
        cmd_test_reg    <= data_out == 8'h36;
        cmd_model_reg   <= data_out == 8'h16;
        cmd_instant_reg <= data_out == 8'h14;
        cmd_inq_reg     <= data_out == 8'h10;
      end else begin
        if (pace_reg != T_LONG) pace_reg <= pace_reg + 1'b1;
        if (fire) begin
          cmd_test_reg    <= 1'b0;
          cmd_model_reg   <= 1'b0;
          cmd_instant_reg <= 1'b0;
          cmd_inq_reg     <= 1'b0;
        end
      end
      if (flush || kp_clr)  kp_phase_reg <= 1'b0;
      else if (kp_set)      kp_phase_reg <= 1'b1;
    end
  end

  assign key_addr   = key_addr_reg;
  assign data_in    = reply_byte;
  assign strobe_in  = fire;
  assign capslock   = capslock_reg;
  assign overflow   = overflow_reg;
  assign fifo_level = count_reg;

endmodule

// File: tb/tb_ps2_mac_kbd_fifo.sv
// Directed bench for ps2_mac_kbd_fifo with a small keymap ROM model and
// shortened reply pacing so inquiry timeouts stay cheap.
`timescale 1ns/1ps
module tb_ps2_mac_kbd_fifo;
  localparam int DEPTH = 8;
  localparam int TS    = 6;
  localparam int TL    = 30;

  logic       clk = 1'b0, reset_n = 1'b0, ce = 1'b1;
  logic [7:0] ibyte = 8'h00, data_out = 8'h00;
  logic       istrobe = 1'b0, strobe_out = 1'b0;
  logic [8:0] key_addr, key_code = 9'h000;
  logic [7:0] data_in;
  logic       strobe_in, capslock, overflow;
  logic [3:0] fifo_level;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  ps2_mac_kbd_fifo #(
    .FIFO_DEPTH(DEPTH), .PACE_W(8), .TICK_SHORT(TS), .TICK_LONG(TL),
    .MODEL_ID(8'h03), .TEST_ACK(8'h7d)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ibyte(ibyte), .istrobe(istrobe),
    .key_addr(key_addr), .key_code(key_code), .data_out(data_out),
    .strobe_out(strobe_out), .data_in(data_in), .strobe_in(strobe_in),
    .capslock(capslock), .overflow(overflow), .fifo_level(fifo_level)
  );

  // keymap ROM: a few fixed keys, 0x20..0x2F -> 0x10..0x1F, everything else unmapped
  function automatic logic [8:0] rom(input logic [8:0] a);
    if (a == 9'h01C) return 9'h001;
    if (a == 9'h069) return 9'h127;
    if (a == 9'h058) return 9'h073;
    if (a[8:4] == 5'h02) return {5'h01, a[3:0]};
    return 9'h07b;
  endfunction

  always @(posedge clk) key_code <= rom(key_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); ibyte = b; istrobe = 1'b1;
    @(negedge clk); istrobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic mac_cmd(input logic [7:0] op);
    @(negedge clk); data_out = op; strobe_out = 1'b1;
    @(negedge clk); strobe_out = 1'b0;
  endtask

  // index i = number of clks (ce=1) since the command was sampled
  task automatic wait_reply(input int max_cyc, output bit got, output logic [7:0] b, output int at);
    got = 1'b0; b = 8'h00; at = -1;
    for (int i = 0; i <= max_cyc; i++) begin
      if (strobe_in === 1'b1) begin
        got = 1'b1; b = data_in; at = i;
        break;
      end
      @(negedge clk);
    end
    if (got) @(negedge clk);
  endtask

  task automatic cmd_expect(input string tag, input logic [7:0] op,
                            input logic [7:0] exp_b, input int exp_at);
    bit got; logic [7:0] b; int at;
    mac_cmd(op);
    wait_reply(TL + 10, got, b, at);
    check({tag, " strobe"}, 32'(got), 32'd1);
    check({tag, " byte"}, 32'(b), 32'(exp_b));
    check({tag, " cycle"}, 32'(at), 32'(exp_at));
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (strobe_in === 1'b1) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got; logic [7:0] b; int at, cnt;

    repeat (2) @(negedge clk);
    check("rst strobe_in", 32'(strobe_in), 32'd0);
    check("rst data_in", 32'(data_in), 32'h7b);
    check("rst capslock", 32'(capslock), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst level", 32'(fifo_level), 32'd0);
    check("rst key_addr", 32'(key_addr), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single key make/break
    send_byte(8'h1C);
    check("a key_addr", 32'(key_addr), 32'h01C);
    check("a level1", 32'(fifo_level), 32'd1);
    send_byte(8'hF0); send_byte(8'h1C);
    check("a level2", 32'(fifo_level), 32'd2);
    cmd_expect("a make", 8'h10, 8'h01, TS);
    cmd_expect("a break", 8'h10, 8'h81, TS);
    check("a level0", 32'(fifo_level), 32'd0);

    // keypad two-part reply
    send_byte(8'h69);
    cmd_expect("kp prefix", 8'h10, 8'h79, TS);
    check("kp level held", 32'(fifo_level), 32'd1);
    cmd_expect("kp code", 8'h10, 8'h27, TS);
    check("kp level0", 32'(fifo_level), 32'd0);

    // idle inquiry times out once; instant replies null
    cmd_expect("idle inq", 8'h10, 8'h7b, TL);
    count_strobes(20, cnt);
    check("idle extra strobes", 32'(cnt), 32'd0);
    cmd_expect("idle instant", 8'h14, 8'h7b, TS);
    cmd_expect("test cmd", 8'h36, 8'h7d, TS);

    // unknown opcode: no reply
    mac_cmd(8'h55);
    wait_reply(TL + 5, got, b, at);
    check("unknown no reply", 32'(got), 32'd0);

    // aborted instant followed by test: only the test reply appears
    mac_cmd(8'h14);
    repeat (2) @(negedge clk);
    cmd_expect("abort", 8'h36, 8'h7d, TS);

    // E0 prefix, unmapped drop, E1 pause skip
    send_byte(8'hE0); send_byte(8'h11);
    check("ext key_addr", 32'(key_addr), 32'h111);
    check("ext dropped", 32'(fifo_level), 32'd0);
    send_byte(8'h7F);
    check("unmapped level", 32'(fifo_level), 32'd0);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    check("pause skipped", 32'(key_addr), 32'h07F);
    send_byte(8'h1C);
    check("after pause addr", 32'(key_addr), 32'h01C);
    check("after pause level", 32'(fifo_level), 32'd1);
    cmd_expect("after pause", 8'h14, 8'h01, TS);

    // locking capslock
    send_byte(8'h58);
    check("caps on", 32'(capslock), 32'd1);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check("caps off", 32'(capslock), 32'd0);
    check("caps level", 32'(fifo_level), 32'd2);
    cmd_expect("caps down", 8'h14, 8'h73, TS);
    cmd_expect("caps up", 8'h14, 8'hF3, TS);

    // flood beyond depth
    for (int i = 0; i < DEPTH + 2; i++) send_byte(8'h20 + 8'(i));
    check("flood level", 32'(fifo_level), 32'(DEPTH));
    check("flood overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cmd_expect($sformatf("drain%0d", i), 8'h14, 8'h10 + 8'(i), TS);
    check("drain level", 32'(fifo_level), 32'd0);

    // model flushes the queue
    send_byte(8'h1C); send_byte(8'h20); send_byte(8'h21);
    check("model pre level", 32'(fifo_level), 32'd3);
    cmd_expect("model", 8'h16, 8'h03, TS);
    check("model flush", 32'(fifo_level), 32'd0);

    // reset mid-inquiry
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check("pre-rst caps", 32'(capslock), 32'd1);
    mac_cmd(8'h10);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid rst strobe_in", 32'(strobe_in), 32'd0);
    check("mid rst data_in", 32'(data_in), 32'h7b);
    check("mid rst capslock", 32'(capslock), 32'd0);
    check("mid rst overflow", 32'(overflow), 32'd0);
    check("mid rst level", 32'(fifo_level), 32'd0);
    check("mid rst key_addr", 32'(key_addr), 32'd0);
    reset_n = 1'b1;
    count_strobes(TL + 5, cnt);
    check("post rst no reply", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
